bt_cmd_parser: RTL and testbench

BT_CMD_PARSER -- requirements
Module: bt_cmd_parser

---
 rtl/bt_cmd_parser.sv | 229 ++++++++++++++++++++++
 tb/tb_bt_cmd_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_cmd_parser.sv
// bt_cmd_parser: parses framed Bluetooth/UART commands for the game core.
// Frame: HEADER, TYPE, ROW, COL, VAL[, CHK]. Validated commands are held on
// cmd_* until handshaken with cmd_ready; rejected frames raise err_pulse.
// Optional feature: define BT_CMD_CHECKSUM_EN to add the trailing XOR
// checksum byte (6-byte frame, err_code 3 possible).
module bt_cmd_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_type,
  output logic [3:0] cmd_row,
  output logic [3:0] cmd_col,
  output logic [3:0] cmd_val,
  output logic       err_pulse,
  output logic [2:0] err_code
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] S_TYPE = 3'd1;
  localparam logic [2:0] S_ROW  = 3'd2;
  localparam logic [2:0] S_COL  = 3'd3;
  localparam logic [2:0] S_VAL  = 3'd4;
`ifdef BT_CMD_CHECKSUM_EN
  localparam logic [2:0] S_CHK  = 3'd5;
  localparam logic [2:0] LAST_ST = S_CHK;
`else
  localparam logic [2:0] LAST_ST = S_VAL;
`endif
  localparam logic [2:0] HOLD   = 3'd6;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_TYPE  = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
`ifdef BT_CMD_CHECKSUM_EN
  localparam logic [2:0] ERR_CHK   = 3'd3;
`endif
  localparam logic [2:0] ERR_TMO   = 3'd4;
  localparam logic [2:0] ERR_OVR   = 3'd5;

  localparam logic [7:0] T_PLACE   = 8'd1;
  localparam logic [7:0] T_CLEAR   = 8'd2;
  localparam logic [7:0] T_NEWGAME = 8'd3;

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    type_q, type_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    col_q, col_d;
`ifdef BT_CMD_CHECKSUM_EN
  logic [7:0]    val_q, val_d;
`endif
  logic          cmd_valid_q, cmd_valid_d;
  logic [1:0]    cmd_type_q, cmd_type_d;
  logic [3:0]    cmd_row_q, cmd_row_d;
  logic [3:0]    cmd_col_q, cmd_col_d;
  logic [3:0]    cmd_val_q, cmd_val_d;
  logic          err_pulse_q, err_pulse_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          last_byte;
  logic          active;
  logic [7:0]    fin_val;
  logic [2:0]    fin_err;
  logic [CW-1:0] cnt_inc;

  // Full-byte range check: 8'h19 must fail even though its low nibble is 9.
  function automatic logic in_rng(input logic [7:0] b);
    return (b >= 8'd1) && (b <= 8'd9);
  endfunction

  // Evaluate the frame as if the current byte were its last one.
  always_comb begin
    last_byte = (state_q == LAST_ST);
    active    = (state_q >= S_TYPE) && (state_q <= LAST_ST);
    cnt_inc   = cnt_q + CW'(1);
`ifdef BT_CMD_CHECKSUM_EN
    fin_val   = val_q;
`else
    fin_val   = rx_data;
`endif
    fin_err   = ERR_NONE;
    if ((type_q < T_PLACE) || (type_q > T_NEWGAME)) begin
      fin_err = ERR_TYPE;
    end else if (((type_q == T_PLACE) &&
                  !(in_rng(row_q) && in_rng(col_q) && in_rng(fin_val))) ||
                 ((type_q == T_CLEAR) && !(in_rng(row_q) && in_rng(col_q)))) begin
      fin_err = ERR_RANGE;
    end
`ifdef BT_CMD_CHECKSUM_EN
    else if ((type_q ^ row_q ^ col_q ^ val_q) != rx_data) begin
      fin_err = ERR_CHK;
    end
`endif
  end

  // Frame FSM, command hold register, error reporting and inter-byte timeout.
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    row_d       = row_q;
    col_d       = col_q;
`ifdef BT_CMD_CHECKSUM_EN
    val_d       = val_q;
`endif
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    cmd_val_d   = cmd_val_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    cnt_d       = '0;

    if (state_q == IDLE) begin
      if (rx_en && (rx_data == HEADER)) begin
        state_d = S_TYPE;
      end
    end else if (state_q == HOLD) begin
      if (cmd_valid_q && cmd_ready) begin
        cmd_valid_d = 1'b0;
        state_d     = IDLE;
      end
      if (rx_en) begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_OVR;
      end
    end else if (active) begin
      // A byte arriving in the timeout cycle takes precedence over the timeout.
      if (rx_en) begin
        if (last_byte) begin
          if (fin_err == ERR_NONE) begin
            state_d     = HOLD;
            cmd_valid_d = 1'b1;
            cmd_type_d  = type_q[1:0];
            cmd_row_d   = '0;
            cmd_col_d   = '0;
            cmd_val_d   = '0;
            if (type_q != T_NEWGAME) begin
              cmd_row_d = row_q[3:0];
              cmd_col_d = col_q[3:0];
            end
            if (type_q == T_PLACE) begin
              cmd_val_d = fin_val[3:0];
            end
          end else begin
            state_d     = IDLE;
            err_pulse_d = 1'b1;
            err_code_d  = fin_err;
          end
        end else begin
          // Data states are consecutive encodings, one step per byte.
          state_d = state_q + 3'd1;
          case (state_q)
            S_TYPE:  type_d = rx_data;
            S_ROW:   row_d  = rx_data;
            S_COL:   col_d  = rx_data;
`ifdef BT_CMD_CHECKSUM_EN
            S_VAL:   val_d  = rx_data;
`endif
            default: ;
          endcase
        end
      end else if (cnt_inc == TMO_LAST) begin
        state_d     = IDLE;
        err_pulse_d = 1'b1;
        err_code_d  = ERR_TMO;
      end else begin
        cnt_d = cnt_inc;
      end
    end else begin
      state_d = IDLE;
    end
  end

  // State registers with synchronous reset; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      type_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
`ifdef BT_CMD_CHECKSUM_EN
      val_q       <= '0;
`endif
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_val_q   <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      row_q       <= row_d;
      col_q       <= col_d;
`ifdef BT_CMD_CHECKSUM_EN
      val_q       <= val_d;
`endif
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_val_q   <= cmd_val_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign cmd_val   = cmd_val_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Directed testbench for bt_cmd_parser (TIMEOUT_CYC reduced to 100).
// Works with or without BT_CMD_CHECKSUM_EN; checksum-only cases are guarded.
module tb_bt_cmd_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_en;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [3:0] cmd_row;
  logic [3:0] cmd_col;
  logic [3:0] cmd_val;
  logic       err_pulse;
  logic [2:0] err_code;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bt_cmd_parser #(
    .HEADER      (8'hA5),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_en     (rx_en),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_val   (cmd_val),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_en   = 1'b1;
    tick();
    rx_en   = 1'b0;
  endtask

  // Sends a full frame; the checksum byte goes out only in the checksum build.
  task automatic send_frame(input logic [7:0] t, input logic [7:0] r,
                            input logic [7:0] c, input logic [7:0] v,
                            input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(t);
    send_byte(r);
    send_byte(c);
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(v);
    send_byte(k);
`else
    send_byte(v);
    if (k == 8'h00) begin end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    rx_data   = '0;
    rx_en     = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_valid", cmd_valid, 0);
    check_eq("rst_type",  cmd_type,  0);
    check_eq("rst_row",   cmd_row,   0);
    check_eq("rst_col",   cmd_col,   0);
    check_eq("rst_val",   cmd_val,   0);
    check_eq("rst_errp",  err_pulse, 0);
    check_eq("rst_errc",  err_code,  0);
    rst = 1'b0;
    tick();

    // Non-header bytes in IDLE are silently ignored.
    send_byte(8'h33);
    send_byte(8'hA4);
    check_eq("idle_junk_errp", err_pulse, 0);
    check_eq("idle_junk_errc", err_code,  0);

    // PLACE 3,7,5 with cmd_ready high: one-cycle valid, then IDLE.
    cmd_ready = 1'b1;
    send_frame(8'h01, 8'h03, 8'h07, 8'h05, 8'h00);
    check_eq("place_valid", cmd_valid, 1);
    check_eq("place_type",  cmd_type,  1);
    check_eq("place_row",   cmd_row,   3);
    check_eq("place_col",   cmd_col,   7);
    check_eq("place_val",   cmd_val,   5);
    check_eq("place_errp",  err_pulse, 0);
    tick();
    check_eq("place_drop",  cmd_valid, 0);

    // CLEAR with row 0A: range error.
    send_frame(8'h02, 8'h0A, 8'h01, 8'h00, 8'h09);
    check_eq("clr_rng_errp",  err_pulse, 1);
    check_eq("clr_rng_errc",  err_code,  2);
    check_eq("clr_rng_valid", cmd_valid, 0);
    tick();
    check_eq("clr_rng_once",  err_pulse, 0);

    // Unknown TYPE 7: type error wins.
    send_frame(8'h07, 8'h01, 8'h01, 8'h01, 8'h06);
    check_eq("type_errp", err_pulse, 1);
    check_eq("type_errc", err_code,  1);

    // Row 19 has low nibble 9 but is out of range as a byte.
    send_frame(8'h01, 8'h19, 8'h01, 8'h01, 8'h18);
    check_eq("byte_rng_errp", err_pulse, 1);
    check_eq("byte_rng_errc", err_code,  2);

    // NEWGAME ignores contents and zeroes the fields.
    send_frame(8'h03, 8'hFF, 8'h00, 8'hAA, 8'h56);
    check_eq("ng_valid", cmd_valid, 1);
    check_eq("ng_type",  cmd_type,  3);
    check_eq("ng_row",   cmd_row,   0);
    check_eq("ng_col",   cmd_col,   0);
    check_eq("ng_val",   cmd_val,   0);
    tick();

    // HEADER value inside a frame is plain data (CLEAR, VAL byte = A5).
    send_frame(8'h02, 8'h04, 8'h05, 8'hA5, 8'hA6);
    check_eq("clr_valid", cmd_valid, 1);
    check_eq("clr_type",  cmd_type,  2);
    check_eq("clr_row",   cmd_row,   4);
    check_eq("clr_col",   cmd_col,   5);
    check_eq("clr_val",   cmd_val,   0);
    tick();

`ifdef BT_CMD_CHECKSUM_EN
    // Bad checksum.
    send_frame(8'h01, 8'h03, 8'h07, 8'h05, 8'h01);
    check_eq("chk_errp",  err_pulse, 1);
    check_eq("chk_errc",  err_code,  3);
    check_eq("chk_valid", cmd_valid, 0);
    tick();
    check_eq("chk_once",  err_pulse, 0);
`endif

    // Overrun while holding: byte dropped, fields untouched, then one handshake.
    cmd_ready = 1'b0;
    send_frame(8'h01, 8'h09, 8'h01, 8'h09, 8'h00);
    check_eq("hold_valid", cmd_valid, 1);
    repeat (3) tick();
    check_eq("hold_stay",  cmd_valid, 1);
    send_byte(8'h55);
    check_eq("ovr_errp",   err_pulse, 1);
    check_eq("ovr_errc",   err_code,  5);
    check_eq("ovr_valid",  cmd_valid, 1);
    check_eq("ovr_row",    cmd_row,   9);
    check_eq("ovr_col",    cmd_col,   1);
    check_eq("ovr_val",    cmd_val,   9);
    tick();
    check_eq("ovr_once",   err_pulse, 0);
    cmd_ready = 1'b1;
    tick();
    check_eq("ovr_hs",     cmd_valid, 0);
    check_eq("ovr_errc_held", err_code, 5);

    // Timeout: error pulse exactly 99 cycles after the TYPE strobe.
    send_byte(8'hA5);
    send_byte(8'h01);
    n = 0;
    while (n < 200) begin
      tick();
      n++;
      if (err_pulse) break;
    end
    check_eq("tmo_cycles", n, 99);
    check_eq("tmo_errc",   err_code, 4);
    tick();
    check_eq("tmo_once",   err_pulse, 0);

    // A byte arriving in the timeout cycle is accepted instead.
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (98) tick();
    send_byte(8'h03);
    check_eq("win_errp", err_pulse, 0);
    send_byte(8'h07);
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(8'h05);
    send_byte(8'h00);
`else
    send_byte(8'h05);
`endif
    check_eq("win_valid", cmd_valid, 1);
    check_eq("win_row",   cmd_row,   3);
    check_eq("win_col",   cmd_col,   7);
    tick();

    // Reset while holding discards the command silently.
    cmd_ready = 1'b0;
    send_frame(8'h02, 8'h04, 8'h05, 8'h00, 8'h03);
    check_eq("rh_valid_pre", cmd_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rh_valid", cmd_valid, 0);
    check_eq("rh_type",  cmd_type,  0);
    check_eq("rh_row",   cmd_row,   0);
    check_eq("rh_errp",  err_pulse, 0);
    check_eq("rh_errc",  err_code,  0);
    cmd_ready = 1'b1;

    // Reset mid-frame: the tail bytes land in IDLE and are ignored.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rm_errp", err_pulse, 0);
    send_byte(8'h07);
`ifdef BT_CMD_CHECKSUM_EN
    send_byte(8'h05);
    send_byte(8'h00);
`else
    send_byte(8'h05);
`endif
    repeat (120) tick();
    check_eq("rm_valid", cmd_valid, 0);
    check_eq("rm_errc",  err_code,  0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
